// File: rtl/bakery_arbiter.sv
// Ticket-ordered (bakery) arbiter: requesters draw consecutive tickets and are
// granted one at a time in ticket order, with an idle cycle between owners.

module bakery_lane #(
   parameter int TKMSB = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             req,
   input  logic             rel,
   input  logic [TKMSB:0]   tk_in,
   input  logic [TKMSB:0]   serve_tk,
   input  logic             any_own,
   output logic             take,
   output logic             own
);
   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_OWN} state_e;

   state_e         state_q, state_d;
   logic [TKMSB:0] tk_q, tk_d;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         tk_q    <= '0;
      end else begin
         state_q <= state_d;
         tk_q    <= tk_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tk_d    = tk_q;
      case (state_q)
         S_IDLE: if (req) begin
            state_d = S_WAIT;
            tk_d    = tk_in;
         end
         // any_own is sampled pre-edge, so a release edge never also grants
         S_WAIT: if (!any_own && (tk_q == serve_tk)) state_d = S_OWN;
         S_OWN:  if (rel) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign take = (state_q == S_IDLE) && req;
   assign own  = (state_q == S_OWN);
endmodule

module bakery_arbiter #(
   parameter int HIPROC = 3,
   parameter int TKMSB  = 3,
   parameter int SELMSB = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [HIPROC:0]   req,
   input  logic [HIPROC:0]   rel,
   output logic [HIPROC:0]   grant,
   output logic              busy,
   output logic [SELMSB:0]   owner,
   output logic [TKMSB:0]    next_tk,
   output logic [TKMSB:0]    serve_tk
);
   logic [HIPROC:0]          take, own;
   logic [HIPROC:0][TKMSB:0] off;
   logic [TKMSB:0]           dispensed;
   logic [TKMSB:0]           next_tk_q, next_tk_d, serve_tk_q, serve_tk_d;
   logic [SELMSB:0]          owner_c;
   logic                     any_own;

   assign any_own = |own;

   // Lower indices drawing at the same edge get the earlier tickets
   always_comb begin
      dispensed = '0;
      for (int i = 0; i <= HIPROC; i++) begin
         off[i]    = next_tk_q + dispensed;
         dispensed = dispensed + (TKMSB+1)'(take[i]);
      end
   end

   for (genvar g = 0; g <= HIPROC; g++) begin : g_lane
      bakery_lane #(.TKMSB(TKMSB)) u_lane (
         .clock    (clock),
         .reset_n  (reset_n),
         .req      (req[g]),
         .rel      (rel[g]),
         .tk_in    (off[g]),
         .serve_tk (serve_tk_q),
         .any_own  (any_own),
         .take     (take[g]),
         .own      (own[g])
      );
   end

   always_comb begin
      next_tk_d  = next_tk_q + dispensed;
      serve_tk_d = serve_tk_q + (TKMSB+1)'(|(own & rel));
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         next_tk_q  <= '0;
         serve_tk_q <= '0;
      end else begin
         next_tk_q  <= next_tk_d;
         serve_tk_q <= serve_tk_d;
      end
   end

   always_comb begin
      owner_c = '0;
      for (int i = 0; i <= HIPROC; i++)
         if (own[i]) owner_c = (SELMSB+1)'(i);
   end

   assign grant    = own;
   assign busy     = any_own;
   assign owner    = owner_c;
   assign next_tk  = next_tk_q;
   assign serve_tk = serve_tk_q;
endmodule

// File: tb/tb_bakery_arbiter.sv
// Bench for bakery_arbiter: directed scenarios plus random traffic, all checked
// against a FIFO-of-waiters model of ticket service.

module tb_bakery_arbiter;
   localparam int N = 4;

   logic       clock = 1'b0;
   logic       reset_n;
   logic [3:0] req, rel, grant;
   logic       busy;
   logic [1:0] owner;
   logic [3:0] next_tk, serve_tk;

   int checks = 0;
   int errors = 0;

   // model: waiters in ticket order, current owner (-1 none), ticket counters
   int q[$];
   int m_own;
   int m_nt, m_st;

   bakery_arbiter #(.HIPROC(3), .TKMSB(3), .SELMSB(1)) dut (
      .clock(clock), .reset_n(reset_n), .req(req), .rel(rel),
      .grant(grant), .busy(busy), .owner(owner),
      .next_tk(next_tk), .serve_tk(serve_tk)
   );

   always #5 clock = ~clock;

   task automatic model_reset();
      q.delete();
      m_own = -1;
      m_nt  = 0;
      m_st  = 0;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic [3:0] l);
      bit idle[N];
      for (int i = 0; i < N; i++) idle[i] = (i != m_own);
      foreach (q[j]) idle[q[j]] = 1'b0;
      if (m_own >= 0 && l[m_own]) begin
         m_own = -1;
         m_st  = (m_st + 1) % 16;
      end else if (m_own < 0 && q.size() > 0) begin
         m_own = q.pop_front();
      end
      for (int i = 0; i < N; i++)
         if (idle[i] && r[i]) begin
            q.push_back(i);
            m_nt = (m_nt + 1) % 16;
         end
   endtask

   function automatic logic [3:0] m_grant();
      return (m_own >= 0) ? 4'(1 << m_own) : 4'b0000;
   endfunction

   function automatic logic [1:0] m_owner();
      return (m_own >= 0) ? 2'(m_own) : 2'd0;
   endfunction

   task automatic step(input logic [3:0] r, input logic [3:0] l);
      @(negedge clock);
      req = r;
      rel = l;
      @(posedge clock);
      model_edge(r, l);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      req = '0;
      rel = '0;
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req = '0;
      rel = '0;
      model_reset();
      #1;
      checks++;
      if (grant !== 4'b0 || busy !== 1'b0 || owner !== 2'd0 || next_tk !== 4'd0 || serve_tk !== 4'd0) begin
         errors++;
         $display("FAIL reset_immediate: grant=%b busy=%b owner=%0d next_tk=%0d serve_tk=%0d, want all 0",
                  grant, busy, owner, next_tk, serve_tk);
      end
      req = 4'b1111;
      repeat (2) @(posedge clock);
      #1;
      checks++;
      if (grant !== 4'b0 || next_tk !== 4'd0) begin
         errors++;
         $display("FAIL reset_held: grant=%b next_tk=%0d, want 0000 0", grant, next_tk);
      end
      @(negedge clock);
      req = '0;
      reset_n = 1'b1;
   endtask

   task automatic test_single();
      step(4'b0100, 4'b0000);
      checks++;
      if (next_tk !== 4'd1 || grant !== 4'b0000) begin
         errors++;
         $display("FAIL single_ticket: next_tk=%0d grant=%b, want 1 0000", next_tk, grant);
      end
      step(4'b0000, 4'b0000);
      checks++;
      if (grant !== 4'b0100 || owner !== 2'd2 || busy !== 1'b1) begin
         errors++;
         $display("FAIL single_grant: grant=%b owner=%0d busy=%b, want 0100 2 1", grant, owner, busy);
      end
      step(4'b0000, 4'b0100);
      checks++;
      if (grant !== 4'b0000 || serve_tk !== 4'd1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_release: grant=%b serve_tk=%0d busy=%b, want 0000 1 0", grant, serve_tk, busy);
      end
   endtask

   task automatic test_simultaneous();
      logic [3:0] order[3];
      order[0] = 4'b0001; order[1] = 4'b0010; order[2] = 4'b1000;
      do_reset();
      step(4'b1011, 4'b0000);
      checks++;
      if (next_tk !== 4'd3 || grant !== 4'b0000) begin
         errors++;
         $display("FAIL simul_tickets: next_tk=%0d grant=%b, want 3 0000", next_tk, grant);
      end
      for (int k = 0; k < 3; k++) begin
         step(4'b0000, 4'b0000);
         checks++;
         if (grant !== order[k] || grant !== m_grant()) begin
            errors++;
            $display("FAIL simul_grant%0d: grant=%b, want %b", k, grant, order[k]);
         end
         step(4'b0000, order[k]);
         checks++;
         if (grant !== 4'b0000 || serve_tk !== 4'(k + 1)) begin
            errors++;
            $display("FAIL simul_gap%0d: grant=%b serve_tk=%0d, want 0000 %0d", k, grant, serve_tk, k + 1);
         end
      end
   endtask

   task automatic test_staggered();
      step(4'b1000, 4'b0000);
      step(4'b0001, 4'b0000);
      checks++;
      if (grant !== 4'b1000 || owner !== 2'd3) begin
         errors++;
         $display("FAIL stagger_first: grant=%b owner=%0d, want 1000 3", grant, owner);
      end
      step(4'b0000, 4'b1000);
      step(4'b0000, 4'b0000);
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("FAIL stagger_second: grant=%b, want 0001", grant);
      end
      step(4'b0000, 4'b0001);
   endtask

   task automatic test_wrap();
      for (int k = 0; k < 17; k++) begin
         logic [3:0] b;
         b = 4'(1 << $urandom_range(0, 3));
         step(b, 4'b0000);
         checks++;
         if (next_tk !== 4'(m_nt)) begin
            errors++;
            $display("FAIL wrap_next_tk%0d: next_tk=%0d, want %0d", k, next_tk, m_nt);
         end
         step(4'b0000, 4'b0000);
         checks++;
         if (grant !== b) begin
            errors++;
            $display("FAIL wrap_grant%0d: grant=%b, want %b", k, grant, b);
         end
         step(4'b0000, b);
         checks++;
         if (serve_tk !== 4'(m_st) || grant !== 4'b0000) begin
            errors++;
            $display("FAIL wrap_serve%0d: serve_tk=%0d grant=%b, want %0d 0000", k, serve_tk, grant, m_st);
         end
      end
   endtask

   task automatic test_ignored();
      logic [3:0] nt0, st0;
      step(4'b0001, 4'b0000);
      step(4'b0000, 4'b0000);
      nt0 = 4'(m_nt);
      st0 = 4'(m_st);
      step(4'b0000, 4'b0010);
      checks++;
      if (grant !== 4'b0001 || serve_tk !== st0) begin
         errors++;
         $display("FAIL ignore_rel: grant=%b serve_tk=%0d, want 0001 %0d", grant, serve_tk, st0);
      end
      step(4'b0001, 4'b0000);
      checks++;
      if (grant !== 4'b0001 || next_tk !== nt0) begin
         errors++;
         $display("FAIL ignore_req: grant=%b next_tk=%0d, want 0001 %0d", grant, next_tk, nt0);
      end
      step(4'b0001, 4'b0001);
      step(4'b0000, 4'b0000);
      checks++;
      if (grant !== 4'b0000 || next_tk !== nt0) begin
         errors++;
         $display("FAIL ignore_relreq: grant=%b next_tk=%0d, want 0000 %0d", grant, next_tk, nt0);
      end
   endtask

   task automatic test_reset_mid();
      step(4'b0010, 4'b0000);
      step(4'b0000, 4'b0000);
      step(4'b0101, 4'b0000);
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0 || next_tk !== 4'd0 || serve_tk !== 4'd0) begin
         errors++;
         $display("FAIL reset_mid: grant=%b busy=%b next_tk=%0d serve_tk=%0d, want 0000 0 0 0",
                  grant, busy, next_tk, serve_tk);
      end
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      req = 4'b0001;
      rel = 4'b0000;
      @(posedge clock);
      model_edge(4'b0001, 4'b0000);
      #1;
      checks++;
      if (next_tk !== 4'd1) begin
         errors++;
         $display("FAIL reset_first_edge: next_tk=%0d, want 1", next_tk);
      end
      step(4'b0000, 4'b0000);
      checks++;
      if (grant !== 4'b0001 || serve_tk !== 4'd0) begin
         errors++;
         $display("FAIL reset_ticket0: grant=%b serve_tk=%0d, want 0001 0", grant, serve_tk);
      end
      step(4'b0000, 4'b0001);
   endtask

   task automatic test_random();
      for (int k = 0; k < 400; k++) begin
         logic [3:0] r, l;
         r = 4'($urandom) & 4'($urandom);
         l = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         step(r, l);
         checks++;
         if (grant !== m_grant() || owner !== m_owner() || busy !== (m_own >= 0) ||
             next_tk !== 4'(m_nt) || serve_tk !== 4'(m_st) || !$onehot0(grant)) begin
            errors++;
            $display("FAIL random%0d: grant=%b owner=%0d busy=%b nt=%0d st=%0d, want %b %0d %b %0d %0d",
                     k, grant, owner, busy, next_tk, serve_tk,
                     m_grant(), m_owner(), (m_own >= 0), m_nt, m_st);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simultaneous();
      test_staggered();
      test_wrap();
      test_ignored();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/bakery_arbiter.md
BAKERY_ARBITER -- requirements
Module: bakery_arbiter

Interface
REQ-001 The block SHALL have parameter HIPROC, default 3: highest requester index; requesters are numbered 0..HIPROC.
REQ-002 The block SHALL have parameter TKMSB, default 3: MSB of ticket and counter values. HIPROC+1 SHALL NOT exceed 2^(TKMSB+1).
REQ-003 The block SHALL have parameter SELMSB, default 1: MSB of the owner index, wide enough to hold HIPROC.
REQ-004 The block SHALL have port clock, input, width 1: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, width HIPROC+1: per-requester ticket request, sampled only in IDLE.
REQ-007 The block SHALL have port rel, input, width HIPROC+1: per-requester release, sampled only in OWN.
REQ-008 The block SHALL have port grant, output, width HIPROC+1: one-hot-or-zero grant of the shared resource, registered.
REQ-009 The block SHALL have port busy, output, width 1: high when any requester is in OWN.
REQ-010 The block SHALL have port owner, output, width SELMSB+1: index of the granted requester; 0 when busy is low.
REQ-011 The block SHALL have port next_tk, output, width TKMSB+1: next ticket to dispense.
REQ-012 The block SHALL have port serve_tk, output, width TKMSB+1: ticket currently being served.

Function
REQ-013 Each requester SHALL have a 3-state FSM (IDLE, WAIT, OWN) and a ticket register of width TKMSB+1.
REQ-014 IDLE->WAIT SHALL occur at an edge where req[n]=1; that edge SHALL load ticket[n].
REQ-015 Simultaneous new requests SHALL get consecutive tickets in ascending index order: ticket[n] = next_tk + (number of requesters with lower index taking a ticket at the same edge).
REQ-016 At that edge, next_tk SHALL advance by the number of tickets dispensed, modulo 2^(TKMSB+1).
REQ-017 WAIT->OWN SHALL occur at an edge where no requester is in OWN and ticket[n]==serve_tk.
REQ-018 A requester entering WAIT at edge k SHALL NOT be granted before edge k+1, so minimum req-to-grant latency is 2 edges.
REQ-019 OWN->IDLE SHALL occur at an edge where rel[n]=1.
REQ-020 At that edge, serve_tk SHALL increment modulo 2^(TKMSB+1).
REQ-021 The next grant SHALL occur no earlier than the following edge, giving one idle cycle between owners.
REQ-022 req[n] SHALL be ignored in WAIT and OWN. Deasserting req[n] in WAIT SHALL NOT cancel the ticket.
REQ-023 rel[n] SHALL be ignored in IDLE and WAIT.
REQ-024 If req[n] and rel[n] are both high in OWN, the release SHALL take effect and the request SHALL be ignored; a new request is accepted from IDLE at a later edge.
REQ-025 grant[n] SHALL equal (state[n]==OWN). At most one grant bit SHALL be high in any cycle.
REQ-026 Ticket arithmetic SHALL be modulo 2^(TKMSB+1). Wrap of next_tk or serve_tk from all-ones to 0 SHALL preserve FIFO service order.
REQ-027 Grant order SHALL be strictly ascending ticket order, so no requester waits more than HIPROC ownership periods.

Reset
REQ-028 While reset_n is low, the following SHALL hold immediately, independent of clock: all FSMs IDLE, all tickets 0, next_tk=0, serve_tk=0, grant=0, busy=0, owner=0.
REQ-029 Reset asserted mid-operation, including during OWN, SHALL discard all outstanding tickets.
REQ-030 The first edge after reset_n rises SHALL already sample req.

Verification (HIPROC=3, TKMSB=3)
REQ-031 Single requester: req=0100 for one edge -> ticket[2]=0 and next_tk=1; next edge grant=0100, owner=2, busy=1; rel=0100 -> grant=0000, serve_tk=1.
REQ-032 Simultaneous requests: req=1011 from idle -> tickets 0,1,3 get 0,1,2, next_tk=3; grants follow in order 0001, 0010, 1000 with one idle cycle between each owner.
REQ-033 Staggered requests: req[3] at edge 1, req[0] at edge 2 -> requester 3 granted first despite its higher index.
REQ-034 Wrap-around: 17 consecutive single-requester grant/release cycles -> next_tk and serve_tk pass 15->0, and each grant still follows ticket order.
REQ-035 Ignored inputs: rel[1] while requester 0 owns -> no change. req[0] while requester 0 owns -> no new ticket and next_tk unchanged.
REQ-036 Reset mid-operation: reset_n low while grant=0010 and two requesters in WAIT -> grant=0000 and next_tk=serve_tk=0 before the next clock edge; after release, req=0001 -> ticket 0.
